// File: rtl/exception_vector_sequencer.sv
// exception_vector_sequencer: saves EPC, fetches the exception vector byte through the address mux and loads it into the PC
module exception_vector_sequencer #(
  parameter int MEM_LATENCY = 1,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_enable,
  input  logic        bad_opcode,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic [31:0] pc_current,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  mem_addr_sel,
  output logic [31:0] epc_out,
  output logic        epc_write,
  output logic [31:0] pc_out,
  output logic        pc_write,
  output logic [1:0]  cause,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ADDR, LOAD, WRITE} state_t;
  localparam logic [2:0] LAST = 3'(MEM_LATENCY - 1);
  state_t state, nstate;
  logic [2:0] cnt, ncnt, sel, nsel;
  logic [1:0] ncause;
  logic take;
  always_comb begin
    take = state == IDLE && exc_enable && (bad_opcode || overflow || div_zero);
    nsel = bad_opcode ? 3'b010 : overflow ? 3'b011 : 3'b100;
    ncause = bad_opcode ? 2'b01 : overflow ? 2'b10 : 2'b11;
    nstate = state;
    ncnt = cnt;
    case (state)
      IDLE: nstate = take ? ADDR : IDLE;
      ADDR: begin
        nstate = cnt == LAST ? LOAD : ADDR;
        ncnt = cnt == LAST ? 3'd0 : cnt + 3'd1;
      end
      LOAD: nstate = WRITE;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 3'd0;
      sel <= 3'd0;
      cause <= 2'b00;
      epc_out <= 32'd0;
      pc_out <= 32'd0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      if (take) begin
        sel <= nsel;
        cause <= ncause;
        epc_out <= pc_current - EPC_OFFSET;
      end
      if (state == LOAD) pc_out <= {24'd0, mem_data_in[7:0]};
    end
  end
  // select is only presented while the memory read is in flight
  assign mem_addr_sel = (state == ADDR || state == LOAD) ? sel : 3'b000;
  assign epc_write = state == ADDR && cnt == 3'd0;
  assign pc_write = state == WRITE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_exception_vector_sequencer.sv
// tb_exception_vector_sequencer: scoreboard bench running latency-1 and latency-3 instances side by side
module tb_exception_vector_sequencer;
  logic clk = 0, reset = 1, exc_enable = 0, bad_opcode = 0, overflow = 0, div_zero = 0;
  logic [31:0] pc_current = 0, mem_data_in = 0;
  logic [2:0] s1, s3;
  logic [31:0] e1, e3, p1, p3;
  logic ew1, ew3, pw1, pw3, b1, b3;
  logic [1:0] c1, c3;
  int total = 0, bad = 0;
  logic [33:0] q1[$], q3[$];
  logic [31:0] eq1[$], eq3[$];
  always #5 clk = ~clk;
  exception_vector_sequencer #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .exc_enable(exc_enable), .bad_opcode(bad_opcode), .overflow(overflow),
    .div_zero(div_zero), .pc_current(pc_current), .mem_data_in(mem_data_in), .mem_addr_sel(s1),
    .epc_out(e1), .epc_write(ew1), .pc_out(p1), .pc_write(pw1), .cause(c1), .busy(b1));
  exception_vector_sequencer #(.MEM_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .exc_enable(exc_enable), .bad_opcode(bad_opcode), .overflow(overflow),
    .div_zero(div_zero), .pc_current(pc_current), .mem_data_in(mem_data_in), .mem_addr_sel(s3),
    .epc_out(e3), .epc_write(ew3), .pc_out(p3), .pc_write(pw3), .cause(c3), .busy(b3));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ew1) begin
      if (eq1.size() == 0) chk("u1 unexpected epc_write", ew1, 1'b0);
      else chk("u1 epc_out", e1, eq1.pop_front());
    end
    if (ew3) begin
      if (eq3.size() == 0) chk("u3 unexpected epc_write", ew3, 1'b0);
      else chk("u3 epc_out", e3, eq3.pop_front());
    end
    if (pw1) begin
      if (q1.size() == 0) chk("u1 unexpected pc_write", pw1, 1'b0);
      else chk("u1 cause/pc_out", {c1, p1}, q1.pop_front());
    end
    if (pw3) begin
      if (q3.size() == 0) chk("u3 unexpected pc_write", pw3, 1'b0);
      else chk("u3 cause/pc_out", {c3, p3}, q3.pop_front());
    end
  end
  task automatic fire(input logic b, input logic o, input logic d, input logic [31:0] pc,
                      input logic [31:0] data, input logic [1:0] ec, input logic expect_pc);
    exc_enable = 1; bad_opcode = b; overflow = o; div_zero = d;
    pc_current = pc; mem_data_in = data;
    eq1.push_back(pc - 32'd4);
    eq3.push_back(pc - 32'd4);
    if (expect_pc) begin
      q1.push_back({ec, 24'd0, data[7:0]});
      q3.push_back({ec, 24'd0, data[7:0]});
    end
  endtask
  task automatic quiet();
    bad_opcode = 0; overflow = 0; div_zero = 0;
  endtask
  task automatic settle();
    repeat (7) @(negedge clk);
    chk("u1 idle", b1, 1'b0);
    chk("u3 idle", b3, 1'b0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset u1 outputs", {s1, e1, ew1, p1, pw1, c1, b1}, 0);
    chk("reset u3 outputs", {s3, e3, ew3, p3, pw3, c3, b3}, 0);
    reset = 0;
    @(negedge clk);
    fire(0, 1, 0, 32'h40, 32'h8C, 2'b10, 1);
    @(negedge clk); quiet();
    chk("ovf T+1 sel", s1, 3'b011);
    chk("ovf T+1 busy", b1, 1'b1);
    @(negedge clk);
    chk("ovf T+2 sel", s1, 3'b011);
    chk("ovf T+2 no pcw", pw1, 1'b0);
    @(negedge clk);
    chk("ovf T+3 sel", s1, 3'b000);
    chk("ovf T+3 pcw", pw1, 1'b1);
    chk("ovf T+3 busy", b1, 1'b1);
    @(negedge clk);
    chk("ovf T+4 busy", b1, 1'b0);
    chk("ovf pc_out held", p1, 32'h8C);
    settle();
    fire(1, 1, 1, 32'h100, 32'h21, 2'b01, 1);
    @(negedge clk); quiet();
    chk("prio sel", s1, 3'b010);
    chk("prio cause", c1, 2'b01);
    settle();
    exc_enable = 0; div_zero = 1;
    repeat (3) @(negedge clk);
    chk("disabled u1 busy", b1, 1'b0);
    chk("disabled u3 busy", b3, 1'b0);
    fire(0, 0, 1, 32'h0, 32'h55, 2'b11, 1);
    @(negedge clk); quiet();
    chk("dz sel", s1, 3'b100);
    chk("dz epc wrap", e1, 32'hFFFF_FFFC);
    settle();
    fire(0, 0, 1, 32'h200, 32'hABCD_12F0, 2'b11, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); quiet();
      chk($sformatf("lat3 T+%0d sel", i), s3, 3'b100);
      chk($sformatf("lat3 T+%0d no pcw", i), pw3, 1'b0);
    end
    @(negedge clk);
    chk("lat3 T+5 sel", s3, 3'b000);
    chk("lat3 T+5 pcw", pw3, 1'b1);
    chk("lat3 T+5 pc_out", p3, 32'hF0);
    settle();
    fire(0, 1, 0, 32'h80, 32'h11, 2'b10, 0);
    @(negedge clk); quiet();
    @(negedge clk);
    chk("rst LOAD state", s1, 3'b011);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst u1 outputs", {s1, e1, ew1, p1, pw1, c1, b1}, 0);
    chk("rst u3 outputs", {s3, e3, ew3, p3, pw3, c3, b3}, 0);
    settle();
    fire(0, 1, 0, 32'h44, 32'h9A, 2'b10, 1);
    @(negedge clk); quiet();
    chk("post-rst sel", s1, 3'b011);
    settle();
    fire(0, 1, 0, 32'h300, 32'h77, 2'b10, 1);
    @(negedge clk); quiet(); bad_opcode = 1;
    @(negedge clk); quiet();
    @(negedge clk); div_zero = 1;
    chk("busy-ign cause", c1, 2'b10);
    @(negedge clk); quiet();
    chk("busy-ign busy drop", b1, 1'b0);
    chk("busy-ign u1 cause", c1, 2'b10);
    settle();
    chk("busy-ign u3 cause", c3, 2'b10);
    chk("q1 drained", q1.size() + eq1.size(), 0);
    chk("q3 drained", q3.size() + eq3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exception_vector_sequencer.md
Name: exception_vector_sequencer

Overview:
- Sequencer on the producing side of the exception-vector address path.
- On an exception event from the datapath (invalid opcode, ALU overflow, divide by zero), it performs four steps:
  - saves the EPC;
  - drives the memory address-source select to the vector byte (253/254/255);
  - waits out the memory read latency;
  - loads the PC with the zero-extended vector byte.
- Sits beside the main control unit, which yields PC/memory control while busy is high.

Parameters:
- MEM_LATENCY, 1, cycles from address-select valid to mem_data_in valid (legal 1..7).
- EPC_OFFSET, 4, subtracted from pc_current to form EPC (PC already advanced at fetch).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- exc_enable  input  1  high when the control unit allows exception sampling (instruction boundary).
- bad_opcode  input  1  invalid opcode detected.
- overflow  input  1  ALU signed overflow.
- div_zero  input  1  divide by zero.
- pc_current  input  32  current PC register value.
- mem_data_in  input  32  memory read data; vector byte is mem_data_in[7:0].
- mem_addr_sel  output  3  address-mux select: 000 idle, 010 = addr 253, 011 = 254, 100 = 255.
- epc_out  output  32  EPC value to store.
- epc_write  output  1  one-cycle EPC write strobe.
- pc_out  output  32  handler address {24'b0, vector byte}.
- pc_write  output  1  one-cycle PC write strobe.
- cause  output  2  00 none, 01 bad opcode, 10 overflow, 11 div zero; held until next exception.
- busy  output  1  high from the first ADDR cycle through the WRITE cycle inclusive.

Behaviour:
- Reset values: all outputs 0, mem_addr_sel = 000, state IDLE, wait counter 0.
- States:
  - IDLE -> ADDR when exc_enable && (bad_opcode|overflow|div_zero) at a rising edge.
  - ADDR holds for MEM_LATENCY cycles, then -> LOAD.
  - LOAD (1 cycle) -> WRITE.
  - WRITE (1 cycle) -> IDLE.
- Priority on simultaneous events: bad_opcode > overflow > div_zero.
  - Select mapping: bad_opcode 010 / cause 01; overflow 011 / cause 10; div_zero 100 / cause 11.
  - Lower-priority events in the same cycle are dropped.
- Sampling edge T (IDLE):
  - latch cause and select;
  - latch epc_out = pc_current - EPC_OFFSET, 32-bit wrap-around (pc_current = 0 gives 0xFFFFFFFC).
- ADDR (first cycle T+1):
  - epc_write = 1 for exactly this cycle;
  - mem_addr_sel driven;
  - busy = 1.
- mem_addr_sel is held constant through ADDR and LOAD.
  - It returns to 000 in WRITE.
- LOAD: pc_out registered from {24'b0, mem_data_in[7:0]} at the end of this cycle. Upper mem_data_in bits are ignored.
- WRITE: pc_write = 1 for one cycle; pc_out valid.
- With MEM_LATENCY = 1: ADDR at T+1, LOAD at T+2, WRITE at T+3, IDLE at T+4.
- Exception inputs and exc_enable are ignored while busy (no queueing).
- A new exception may be accepted on the edge that ends WRITE only if busy has already dropped, i.e. from IDLE. There is therefore at least one IDLE cycle between sequences.
- Reset asserted in any state:
  - next edge returns to IDLE;
  - all strobes 0, select 000, cause 00, pc_out/epc_out cleared;
  - no partial PC write occurs.
- Input held high with exc_enable held high: re-triggers after each return to IDLE (one sequence per IDLE sample).
- pc_out and epc_out hold their last values in IDLE until the next sequence or reset.

Test Plan:
- Overflow with pc_current = 0x0000_0040, mem_data_in[7:0] = 0x8C:
  - epc_write pulse at T+1 with epc_out = 0x3C;
  - mem_addr_sel = 011 for T+1..T+2;
  - pc_write at T+3 with pc_out = 0x8C, cause = 10.
- bad_opcode, overflow and div_zero asserted together:
  - select 010, cause 01;
  - exactly one sequence.
- div_zero with exc_enable = 0 -> no response. Then with exc_enable = 1, pc_current = 0 -> select 100, epc_out = 0xFFFFFFFC.
- MEM_LATENCY = 3, div_zero, mem_data_in = 0xABCD_12F0:
  - select held 4 cycles (ADDR ×3 + LOAD);
  - pc_write at T+5, pc_out = 0x0000_00F0.
- Reset asserted during LOAD -> next cycle all outputs 0, no pc_write ever pulses; a new overflow afterwards runs normally.
- New exception pulses during ADDR/WRITE -> ignored; cause unchanged; busy drops after WRITE.
